// File: rtl/ddr5_cmd_issuer.sv
// DDR5 closed-page command issuer: one request in flight,
// ACT0/ACT1 -> RD/WR pair -> PRE, all timing off one cycle counter.
module ddr5_cmd_issuer #(
   parameter int T_RCD   = 39,
   parameter int T_RAS   = 76,
   parameter int T_RTP   = 18,
   parameter int T_CWL   = 38,
   parameter int T_BURST = 8,
   parameter int T_WR    = 72,
   parameter int T_RP    = 39
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_opn,
   input  logic [33:0] req_addr,
   output logic        cmd_valid,
   output logic [2:0]  cmd_code,
   output logic        cmd_chan,
   output logic [2:0]  cmd_bg,
   output logic [1:0]  cmd_bank,
   output logic [15:0] cmd_row,
   output logic [9:0]  cmd_col,
   output logic        req_done
);

   localparam int RD_END = T_RCD + T_RTP;
   localparam int WR_END = T_RCD + T_CWL + T_BURST + T_WR;
   localparam int RD_P0  = (T_RAS > RD_END) ? T_RAS : RD_END;
   localparam int WR_P0  = (T_RAS > WR_END) ? T_RAS : WR_END;
   // PRE can never come before the CAS pair has gone out
   localparam int P_RD   = (RD_P0 > T_RCD + 2) ? RD_P0 : T_RCD + 2;
   localparam int P_WR   = (WR_P0 > T_RCD + 2) ? WR_P0 : T_RCD + 2;
   localparam int P_MAX  = (P_RD > P_WR) ? P_RD : P_WR;
   localparam int CW     = $clog2(P_MAX + T_RP + 1);

   localparam logic [2:0] C_NOP  = 3'd0;
   localparam logic [2:0] C_ACT0 = 3'd1;
   localparam logic [2:0] C_ACT1 = 3'd2;
   localparam logic [2:0] C_RD0  = 3'd3;
   localparam logic [2:0] C_RD1  = 3'd4;
   localparam logic [2:0] C_WR0  = 3'd5;
   localparam logic [2:0] C_WR1  = 3'd6;
   localparam logic [2:0] C_PRE  = 3'd7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ACT0,
      S_ACT1,
      S_WAIT_RCD,
      S_CAS0,
      S_CAS1,
      S_WAIT_PRE,
      S_PRE,
      S_WAIT_RP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_done;
   logic            r_rdy_en;
   logic            r_wr;
   logic [15:0]     r_row;
   logic [9:0]      r_col;
   logic [1:0]      r_bank;
   logic [2:0]      r_bg;
   logic            r_chan;
   logic            w_done_nxt;
   logic            w_accept;
   logic [CW-1:0]   w_rcd_m1;
   logic [CW-1:0]   w_pre_m1;
   logic [CW-1:0]   w_end_m1;
   logic            w_unused;

   assign w_unused  = ^req_addr[1:0];
   assign req_ready = (r_state == S_IDLE) & r_rdy_en;
   assign w_accept  = req_valid & req_ready;
   assign req_done  = r_done;

   // Counter holds cycles since ACT0; each wait ends one cycle early
   assign w_rcd_m1 = CW'(T_RCD - 1);
   assign w_pre_m1 = r_wr ? CW'(P_WR - 1) : CW'(P_RD - 1);
   assign w_end_m1 = r_wr ? CW'(P_WR + T_RP - 1)
                          : CW'(P_RD + T_RP - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_rdy_en <= 1'b0;
         r_wr     <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         r_bank   <= '0;
         r_bg     <= '0;
         r_chan   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= (r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
         r_done   <= w_done_nxt;
         r_rdy_en <= 1'b1;
         if (w_accept) begin
            r_wr   <= (req_opn == 2'd1);
            r_row  <= req_addr[33:18];
            r_col  <= {req_addr[17:12], req_addr[5:2]};
            r_bank <= req_addr[11:10];
            r_bg   <= req_addr[9:7];
            r_chan <= req_addr[6];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (req_opn == 2'd3) w_done_nxt  = 1'b1;
               else                 w_state_nxt = S_ACT0;
            end
         end
         S_ACT0: w_state_nxt = S_ACT1;
         S_ACT1, S_WAIT_RCD: begin
            w_state_nxt = (r_cnt == w_rcd_m1) ? S_CAS0 : S_WAIT_RCD;
         end
         S_CAS0: w_state_nxt = S_CAS1;
         S_CAS1, S_WAIT_PRE: begin
            w_state_nxt = (r_cnt == w_pre_m1) ? S_PRE : S_WAIT_PRE;
         end
         S_PRE, S_WAIT_RP: begin
            if (r_cnt == w_end_m1) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_WAIT_RP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_code = C_NOP;
      cmd_row  = '0;
      cmd_col  = '0;
      unique case (r_state)
         S_ACT0: begin
            cmd_code = C_ACT0;
            cmd_row  = r_row;
         end
         S_ACT1: begin
            cmd_code = C_ACT1;
            cmd_row  = r_row;
         end
         S_CAS0: begin
            cmd_code = r_wr ? C_WR0 : C_RD0;
            cmd_col  = r_col;
         end
         S_CAS1: begin
            cmd_code = r_wr ? C_WR1 : C_RD1;
            cmd_col  = r_col;
         end
         S_PRE: cmd_code = C_PRE;
         default: cmd_code = C_NOP;
      endcase
   end

   assign cmd_valid = (cmd_code != C_NOP);
   assign cmd_chan  = cmd_valid ? r_chan : 1'b0;
   assign cmd_bg    = cmd_valid ? r_bg   : 3'd0;
   assign cmd_bank  = cmd_valid ? r_bank : 2'd0;

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Scoreboard bench for ddr5_cmd_issuer: default timing instance
// plus a minimum-timing instance, both checked cycle-exactly.
module tb_ddr5_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  vld;
   logic [1:0]  opn;
   logic [33:0] addr;

   logic        rdy[2];
   logic        cval[2];
   logic        chan[2];
   logic        done[2];
   logic [2:0]  code[2];
   logic [2:0]  bg[2];
   logic [1:0]  bank[2];
   logic [15:0] row[2];
   logic [9:0]  col[2];

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int rdy_at[2] = '{1000000, 1000000};

   typedef struct {
      int          cyc;
      logic [36:0] v;
   } ev_t;
   ev_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ddr5_cmd_issuer u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(vld[0]), .req_ready(rdy[0]),
      .req_opn(opn), .req_addr(addr),
      .cmd_valid(cval[0]), .cmd_code(code[0]),
      .cmd_chan(chan[0]), .cmd_bg(bg[0]),
      .cmd_bank(bank[0]), .cmd_row(row[0]),
      .cmd_col(col[0]), .req_done(done[0])
   );

   ddr5_cmd_issuer #(
      .T_RCD(2), .T_RAS(3), .T_RTP(2), .T_RP(1)
   ) u_small (
      .clk(clk), .rst_n(rst_n),
      .req_valid(vld[1]), .req_ready(rdy[1]),
      .req_opn(opn), .req_addr(addr),
      .cmd_valid(cval[1]), .cmd_code(code[1]),
      .cmd_chan(chan[1]), .cmd_bg(bg[1]),
      .cmd_bank(bank[1]), .cmd_row(row[1]),
      .cmd_col(col[1]), .req_done(done[1])
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h cyc=%0d",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic logic [36:0] mk(
      input int k, input logic d, input logic [2:0] c,
      input logic ch, input logic [2:0] g,
      input logic [1:0] b, input logic [15:0] r,
      input logic [9:0] cl);
      logic kb;
      kb = (k != 0);
      return {kb, d, c, ch, g, b, r, cl};
   endfunction

   function automatic void push(input int t, input logic [36:0] v);
      ev_t e;
      e.cyc = t;
      e.v   = v;
      sb.push_back(e);
   endfunction

   function automatic int imax(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   function automatic void push_req(input int k, input int a,
                                    input logic [1:0] o,
                                    input logic [33:0] ad);
      int rcd, ras, rtp, rp, p, c0;
      logic ch, wr;
      logic [2:0] g;
      logic [1:0] b;
      logic [15:0] r;
      logic [9:0] cl;
      rcd = (k != 0) ? 2 : 39;
      ras = (k != 0) ? 3 : 76;
      rtp = (k != 0) ? 2 : 18;
      rp  = (k != 0) ? 1 : 39;
      ch  = ad[6];
      g   = ad[9:7];
      b   = ad[11:10];
      r   = ad[33:18];
      cl  = {ad[17:12], ad[5:2]};
      if (o == 2'd3) begin
         push(a + 1, mk(k, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 10'd0));
         rdy_at[k] = a + 1;
         return;
      end
      wr = (o == 2'd1);
      c0 = a + 1;
      p  = wr ? imax(ras, rcd + 38 + 8 + 72) : imax(ras, rcd + rtp);
      push(c0,     mk(k, 1'b0, 3'd1, ch, g, b, r, 10'd0));
      push(c0 + 1, mk(k, 1'b0, 3'd2, ch, g, b, r, 10'd0));
      push(c0 + rcd,
           mk(k, 1'b0, wr ? 3'd5 : 3'd3, ch, g, b, 16'd0, cl));
      push(c0 + rcd + 1,
           mk(k, 1'b0, wr ? 3'd6 : 3'd4, ch, g, b, 16'd0, cl));
      push(c0 + p, mk(k, 1'b0, 3'd7, ch, g, b, 16'd0, 10'd0));
      push(c0 + p + rp,
           mk(k, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 16'd0, 10'd0));
      rdy_at[k] = c0 + p + rp;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (cyc > 0) begin
            logic [36:0] obs;
            ev_t e;
            obs = mk(k, done[k], code[k], chan[k], bg[k],
                     bank[k], row[k], col[k]);
            chk("ready", 64'(rdy[k]), 64'(cyc >= rdy_at[k]));
            if (cval[k] !== (code[k] != 3'd0))
               chk("cmd_valid", 64'(cval[k]), 64'(code[k] != 3'd0));
            if (cval[k] || done[k]) begin
               if (sb.size() == 0) begin
                  chk("unexpected_evt", 64'(obs), 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("evt_cycle", 64'(cyc), 64'(e.cyc));
                  chk("evt", 64'(obs), 64'(e.v));
               end
            end
         end
         if (!rst_n) begin
            rdy_at[k] = cyc + 2;
            sb.delete();
         end else if (vld[k] && rdy[k]) begin
            push_req(k, cyc, opn, addr);
         end
      end
   end

   function automatic logic [33:0] rnd34();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[33:0];
   endfunction

   task automatic send(input int k, input logic [1:0] o,
                       input logic [33:0] ad, output int acc);
      bit got;
      got = 0;
      acc = -1;
      @(posedge clk); #1;
      vld[k] = 1'b1;
      opn    = o;
      addr   = ad;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (rdy[k] && rst_n) begin
            acc = cyc;
            got = 1;
         end
      end
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      vld[k] = 1'b0;
      opn    = 2'($urandom());
      addr   = rnd34();
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() != 0; n++)
         @(posedge clk);
      chk("drain", 64'(sb.size()), 64'd0);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a2;
      bit got;
      rst_n = 1'b0;
      vld   = 2'b00;
      opn   = 2'd0;
      addr  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready_low", 64'(rdy[0]), 64'd0);
      chk("rst_code", 64'(code[0]), 64'd0);
      repeat (2) @(posedge clk);

      send(0, 2'd0, 34'h1_2345_6789, a);
      drain();
      send(0, 2'd1, 34'h1_2345_6789, a);
      drain();
      send(0, 2'd2, rnd34(), a);
      drain();
      send(0, 2'd3, rnd34(), a);
      send(0, 2'd0, rnd34(), a);
      drain();

      got = 0;
      a2  = -1;
      @(posedge clk); #1;
      vld[0] = 1'b1;
      opn    = 2'd0;
      addr   = rnd34();
      send_wait: for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (rdy[0]) got = 1;
      end
      a1 = cyc;
      @(posedge clk); #1;
      addr = rnd34();
      got  = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (rdy[0]) begin
            a2  = cyc;
            got = 1;
         end
      end
      chk("b2b_gap", 64'(a2 - a1), 64'd116);
      @(posedge clk); #1;
      vld[0] = 1'b0;
      drain();

      send(0, 2'd1, rnd34(), a);
      while (cyc < a + 50) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_outs",
          64'({cval[0], code[0], chan[0], bg[0], bank[0],
               row[0], col[0], done[0], rdy[0]}), 64'd0);
      @(negedge clk);
      chk("rst_ready_back", 64'(rdy[0]), 64'd1);
      repeat (3) @(posedge clk);
      drain();

      send(1, 2'd0, rnd34(), a);
      drain();
      send(1, 2'd1, rnd34(), a);
      drain();
      send(1, 2'd3, rnd34(), a);
      send(1, 2'd2, rnd34(), a);
      drain();

      for (int i = 0; i < 4; i++) begin
         send(0, 2'($urandom_range(0, 3)), rnd34(), a);
         drain();
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
